// File: rtl/instruction_issuer_pkg.sv
// Shared constants and FSM state encoding for the instruction issuer.
package instruction_issuer_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int ISSUE_FIFO_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } issuer_state_e;

endpackage

// File: rtl/instruction_issuer_queue.sv
// Circular instruction buffer with registered level and empty/full flags.
// Storage is not reset; only pointers and flags are.
module instruction_issuer_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = '0;
    localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_empty;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_level_next;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LVL_ONE;
        end else begin
            w_level_next = r_level;
        end
    end

    // Pointers, level and flags; clear wins over any push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= LVL_ZERO;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= LVL_ZERO;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level <= w_level_next;
            r_empty <= (w_level_next == LVL_ZERO);
            r_full  <= (w_level_next == LVL_FULL);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/instruction_issuer.sv
// Issues queued instructions to a core one at a time: start pulse, wait for
// busy to rise (with timeout), wait for busy to fall, then pop and count.
module instruction_issuer
    import instruction_issuer_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = instruction_issuer_pkg::INSTRUCTION_WIDTH,
    parameter int DEPTH             = ISSUE_FIFO_DEPTH,
    parameter int BUSY_TIMEOUT      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         loadValid,
    input  logic [INSTRUCTION_WIDTH-1:0] loadInstruction,
    output logic                         loadReady,
    input  logic                         runEnable,
    input  logic                         flush,
    input  logic                         coreBusy,
    output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
    output logic                         start,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         empty,
    output logic                         full,
    output logic                         idle,
    output logic [15:0]                  issuedCount,
    output logic                         timeoutError
);

    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_ONE      = {{(TW-1){1'b0}}, 1'b1};

    issuer_state_e r_state;
    logic          r_idle;
    logic          r_start;
    logic [TW-1:0] r_timeout_cnt;
    logic [15:0]   r_issued_count;
    logic          r_timeout_error;
    logic          w_clear;
    logic          w_push;
    logic          w_pop;

    assign w_clear = (r_state == ST_IDLE) && flush;
    assign w_push  = loadValid && !full && !w_clear;
    assign w_pop   = (r_state == ST_WAIT_DONE) && !coreBusy;

    instruction_issuer_queue #(
        .WIDTH (INSTRUCTION_WIDTH),
        .DEPTH (DEPTH)
    ) u_instructionQueue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (loadInstruction),
        .o_head  (instructionOut),
        .o_level (level),
        .o_empty (empty),
        .o_full  (full)
    );

    // Issue FSM with timeout counter, completion counter and start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_idle          <= 1'b1;
            r_start         <= 1'b0;
            r_timeout_cnt   <= '0;
            r_issued_count  <= 16'd0;
            r_timeout_error <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        r_timeout_error <= 1'b0;
                    end else if (runEnable && !empty && !coreBusy) begin
                        r_state       <= ST_WAIT_BUSY;
                        r_idle        <= 1'b0;
                        r_start       <= 1'b1;
                        r_timeout_cnt <= '0;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (coreBusy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                        // Head stays queued so the next issue retries it.
                        r_timeout_error <= 1'b1;
                        r_state         <= ST_IDLE;
                        r_idle          <= 1'b1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + CNT_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!coreBusy) begin
                        r_issued_count <= r_issued_count + 16'd1;
                        r_state        <= ST_IDLE;
                        r_idle         <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign loadReady    = !full;
    assign start        = r_start;
    assign idle         = r_idle;
    assign issuedCount  = r_issued_count;
    assign timeoutError = r_timeout_error;

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed self-checking bench for instruction_issuer with a simple core model.
module tb_instruction_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        loadValid = 1'b0;
    logic [31:0] loadInstruction = 32'd0;
    logic        loadReady;
    logic        runEnable = 1'b0;
    logic        flush = 1'b0;
    logic        coreBusy;
    logic [31:0] instructionOut;
    logic        start;
    logic [3:0]  level;
    logic        empty, full, idle;
    logic [15:0] issuedCount;
    logic        timeoutError;

    int n_checks = 0;
    int n_pass = 0;
    int busy_viol = 0;
    logic core_en = 1'b0;
    int busy_cycles = 3;
    int busy_left;
    logic [31:0] start_log[$];

    instruction_issuer dut (
        .clk(clk), .reset(reset), .loadValid(loadValid), .loadInstruction(loadInstruction),
        .loadReady(loadReady), .runEnable(runEnable), .flush(flush), .coreBusy(coreBusy),
        .instructionOut(instructionOut), .start(start), .level(level), .empty(empty),
        .full(full), .idle(idle), .issuedCount(issuedCount), .timeoutError(timeoutError)
    );

    always #5 clk = ~clk;

    // Core model: busy rises the edge after start and stays high busy_cycles+1 cycles.
    always @(posedge clk) begin
        if (!core_en || reset) begin
            coreBusy  <= 1'b0;
            busy_left <= 0;
        end else if (start && !coreBusy) begin
            coreBusy  <= 1'b1;
            busy_left <= busy_cycles;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else begin
            coreBusy <= 1'b0;
        end
    end

    // Start monitor: record the issued word and watch start against busy.
    always @(negedge clk) begin
        if (!reset && start) start_log.push_back(instructionOut);
        if (start && coreBusy) busy_viol <= busy_viol + 1;
    end

    task automatic do_reset();
        reset = 1'b1;
        loadValid = 1'b0;
        runEnable = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        start_log.delete();
    endtask

    task automatic push(input logic [31:0] d);
        loadValid = 1'b1;
        loadInstruction = d;
        @(posedge clk); #1;
        loadValid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_checks++; if (loadReady !== 1'b1) $display("FAIL reset_loadReady: got %b want 1", loadReady); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL reset_start: got %b want 0", start); else n_pass++;
        n_checks++; if (issuedCount !== 16'd0) $display("FAIL reset_issued: got %0d want 0", issuedCount); else n_pass++;
        n_checks++; if (timeoutError !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeoutError); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_issue();
        logic [31:0] exp_words [3];
        int n;
        exp_words[0] = 32'h00100093;
        exp_words[1] = 32'h00200113;
        exp_words[2] = 32'h002081B3;
        do_reset();
        core_en = 1'b1;
        busy_cycles = 3;
        runEnable = 1'b1;
        for (int i = 0; i < 3; i++) push(exp_words[i]);
        n = 0;
        while (issuedCount !== 16'd3 && n < 100) begin @(posedge clk); #1; n++; end
        n_checks++; if (issuedCount !== 16'd3) $display("FAIL issue_count: got %0d want 3", issuedCount); else n_pass++;
        n_checks++; if (start_log.size() !== 3) $display("FAIL issue_starts: got %0d want 3", start_log.size()); else n_pass++;
        for (int i = 0; i < 3 && i < start_log.size(); i++) begin
            n_checks++;
            if (start_log[i] !== exp_words[i]) $display("FAIL issue_order[%0d]: got %h want %h", i, start_log[i], exp_words[i]);
            else n_pass++;
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL issue_empty: got %b want 1", empty); else n_pass++;
        runEnable = 1'b0;
    endtask

    task automatic test_full_and_wrap();
        int n;
        do_reset();
        core_en = 1'b1;
        busy_cycles = 3;
        for (int i = 0; i < 9; i++) push(32'hA0 + i);
        n_checks++; if (level !== 4'd8) $display("FAIL full_level: got %0d want 8", level); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else n_pass++;
        n_checks++; if (loadReady !== 1'b0) $display("FAIL full_loadReady: got %b want 0", loadReady); else n_pass++;
        // One issue with runEnable pulsed, while a push is held pending.
        loadValid = 1'b1;
        loadInstruction = 32'hB0;
        runEnable = 1'b1;
        @(posedge clk); #1;
        runEnable = 1'b0;
        n = 0;
        while (issuedCount !== 16'd1 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        loadValid = 1'b0;
        n_checks++; if (issuedCount !== 16'd1) $display("FAIL wrap_first_issue: got %0d want 1", issuedCount); else n_pass++;
        n_checks++; if (level !== 4'd8) $display("FAIL wrap_level: got %0d want 8", level); else n_pass++;
        n_checks++; if (start_log.size() !== 1) $display("FAIL run_disable_starts: got %0d want 1", start_log.size()); else n_pass++;
        runEnable = 1'b1;
        n = 0;
        while (issuedCount !== 16'd9 && n < 300) begin @(posedge clk); #1; n++; end
        runEnable = 1'b0;
        n_checks++; if (start_log.size() !== 9) $display("FAIL wrap_starts: got %0d want 9", start_log.size()); else n_pass++;
        for (int i = 0; i < 9 && i < start_log.size(); i++) begin
            n_checks++;
            if (start_log[i] !== ((i < 8) ? (32'hA0 + i) : 32'hB0))
                $display("FAIL wrap_order[%0d]: got %h want %h", i, start_log[i], (i < 8) ? (32'hA0 + i) : 32'hB0);
            else n_pass++;
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        core_en = 1'b0;
        push(32'h11);
        push(32'h22);
        runEnable = 1'b1;
        n = 0;
        while (start !== 1'b1 && n < 5) begin @(posedge clk); #1; n++; end
        n_checks++; if (start !== 1'b1) $display("FAIL timeout_start: got %b want 1", start); else n_pass++;
        n = 0;
        while (timeoutError !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_checks++; if (n !== 8) $display("FAIL timeout_latency: got %0d want 8", n); else n_pass++;
        n_checks++; if (level !== 4'd2) $display("FAIL timeout_level: got %0d want 2", level); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (start !== 1'b1) $display("FAIL retry_start: got %b want 1", start); else n_pass++;
        n_checks++; if (instructionOut !== 32'h11) $display("FAIL retry_head: got %h want 00000011", instructionOut); else n_pass++;
        runEnable = 1'b0;
        n = 0;
        while (idle !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_checks++; if (idle !== 1'b1) $display("FAIL retry_idle: got %b want 1", idle); else n_pass++;
    endtask

    // Continues from test_timeout: two entries queued, timeoutError set.
    task automatic test_flush();
        int n;
        core_en = 1'b1;
        busy_cycles = 10;
        for (int i = 0; i < 4; i++) push(32'h33 + 32'h11 * i);
        runEnable = 1'b1;
        @(posedge clk); #1;
        runEnable = 1'b0;
        n = 0;
        while (coreBusy !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++; if (level !== 4'd6) $display("FAIL flush_busy_level: got %0d want 6", level); else n_pass++;
        n_checks++; if (timeoutError !== 1'b1) $display("FAIL flush_busy_err: got %b want 1", timeoutError); else n_pass++;
        n = 0;
        while (issuedCount !== 16'd1 && n < 40) begin @(posedge clk); #1; n++; end
        n_checks++; if (level !== 4'd5) $display("FAIL flush_pre_level: got %0d want 5", level); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL flush_pre_idle: got %b want 1", idle); else n_pass++;
        n_checks++;
        if (start_log.size() == 0 || start_log[start_log.size()-1] !== 32'h11)
            $display("FAIL flush_issued_head: got %0d entries, want last 00000011", start_log.size());
        else n_pass++;
        flush = 1'b1;
        loadValid = 1'b1;
        loadInstruction = 32'h77;
        @(posedge clk); #1;
        flush = 1'b0;
        loadValid = 1'b0;
        n_checks++; if (level !== 4'd0) $display("FAIL flush_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (timeoutError !== 1'b0) $display("FAIL flush_err: got %b want 0", timeoutError); else n_pass++;
    endtask

    task automatic test_reset_mid_issue();
        int n;
        int ns;
        do_reset();
        core_en = 1'b1;
        busy_cycles = 10;
        runEnable = 1'b1;
        push(32'hC1);
        push(32'hC2);
        n = 0;
        while (coreBusy !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++; if (level !== 4'd0) $display("FAIL midrst_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL midrst_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL midrst_idle: got %b want 1", idle); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL midrst_start: got %b want 0", start); else n_pass++;
        n_checks++; if (issuedCount !== 16'd0) $display("FAIL midrst_issued: got %0d want 0", issuedCount); else n_pass++;
        n_checks++; if (loadReady !== 1'b1) $display("FAIL midrst_loadReady: got %b want 1", loadReady); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        ns = start_log.size();
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (start_log.size() !== ns) $display("FAIL midrst_no_start: got %0d want %0d", start_log.size(), ns); else n_pass++;
        n_checks++; if (issuedCount !== 16'd0) $display("FAIL midrst_no_pop: got %0d want 0", issuedCount); else n_pass++;
        runEnable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_issue();
        test_full_and_wrap();
        test_timeout();
        test_flush();
        test_reset_mid_issue();
        n_checks++; if (busy_viol !== 0) $display("FAIL start_while_busy: got %0d want 0", busy_viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
